// File: rtl/branch_resolve_unit.sv
// Registered branch resolver: flags register with bypass, circular return-address stack,
// 1-cycle valid/ready result. Optional counters under `BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4,
  parameter int PC_INC    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [PC_W-1:0] in_target,
  input  logic [2:0]      in_btype,
  input  logic            flags_wr,
  input  logic [1:0]      flags_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [PC_W-1:0] out_branchpc,
  output logic            out_err,
  output logic [15:0]     stat_taken,
  output logic [15:0]     stat_nottaken
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_flags;

  logic            w_accept;
  logic [1:0]      w_flags;
  logic [PW-1:0]   w_top_idx;
  logic            w_empty;
  logic [PC_W-1:0] w_link;
  logic            w_taken, w_err, w_push, w_pop;
  logic [PC_W-1:0] w_pc;

  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  // A same-cycle flags write is visible to the op being evaluated.
  assign w_flags   = flags_wr ? flags_in : r_flags;
  assign w_top_idx = r_ptr - PW'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_link    = in_pc + PC_W'(PC_INC);

  always_comb begin
    w_taken = 1'b0;
    w_pc    = '0;
    w_err   = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    case (in_btype)
      3'd0: ;
      3'd1: begin w_taken = 1'b1; w_pc = in_target; end
      3'd2: begin w_taken = w_flags[0]; w_pc = w_flags[0] ? in_target : '0; end
      3'd3: begin w_taken = w_flags[1]; w_pc = w_flags[1] ? in_target : '0; end
      3'd4: begin w_taken = 1'b1; w_pc = in_target; w_push = 1'b1; end
      3'd5: begin
        if (w_empty) w_err = 1'b1;
        else begin w_taken = 1'b1; w_pc = r_ras[w_top_idx]; w_pop = 1'b1; end
      end
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_flags <= 2'b00;
    else if (flags_wr) r_flags <= flags_in;
  end

  // Full stack: the write pointer lands on the oldest entry, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_accept && w_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (r_cnt != CW'(RAS_DEPTH)) r_cnt <= r_cnt + CW'(1);
    end else if (w_accept && w_pop) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_push) r_ras[r_ptr] <= w_link;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid    <= 1'b0;
      out_taken    <= 1'b0;
      out_err      <= 1'b0;
      out_branchpc <= '0;
    end else if (w_accept) begin
      out_valid    <= 1'b1;
      out_taken    <= w_taken;
      out_err      <= w_err;
      out_branchpc <= w_pc;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic        w_count;
  logic [15:0] r_stat_taken, r_stat_nottaken;

  // Reserved encodings and 'none' are excluded; flush does not suppress counting.
  assign w_count = w_accept && (in_btype >= 3'd1) && (in_btype <= 3'd5);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_taken    <= '0;
      r_stat_nottaken <= '0;
    end else if (w_count) begin
      if (w_taken) begin
        if (r_stat_taken != 16'hFFFF) r_stat_taken <= r_stat_taken + 16'd1;
      end else begin
        if (r_stat_nottaken != 16'hFFFF) r_stat_nottaken <= r_stat_nottaken + 16'd1;
      end
    end
  end

  assign stat_taken    = r_stat_taken;
  assign stat_nottaken = r_stat_nottaken;
`else
  assign stat_taken    = '0;
  assign stat_nottaken = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed table-driven bench for branch_resolve_unit plus backpressure/flush sequences.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_pc, in_target;
  logic [2:0]  in_btype;
  logic        flags_wr;
  logic [1:0]  flags_in;
  logic        flush;
  logic        out_valid, out_ready, out_taken, out_err;
  logic [15:0] out_branchpc, stat_taken, stat_nottaken;

  int total = 0;
  int bad   = 0;
  int exp_t = 0;
  int exp_n = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(16), .RAS_DEPTH(4), .PC_INC(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_target(in_target), .in_btype(in_btype),
    .flags_wr(flags_wr), .flags_in(flags_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_branchpc(out_branchpc), .out_err(out_err),
    .stat_taken(stat_taken), .stat_nottaken(stat_nottaken)
  );

  typedef struct {
    logic        fwr;
    logic [1:0]  fin;
    logic [2:0]  bt;
    logic [15:0] pc;
    logic [15:0] tgt;
    logic        e_tk;
    logic [15:0] e_pc;
    logic        e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic fwr, input logic [1:0] fin, input logic [2:0] bt,
                              input logic [15:0] pc, input logic [15:0] tgt,
                              input logic e_tk, input logic [15:0] e_pc, input logic e_err);
    vec_t v;
    v.fwr = fwr; v.fin = fin; v.bt = bt; v.pc = pc; v.tgt = tgt;
    v.e_tk = e_tk; v.e_pc = e_pc; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic count(input logic [2:0] bt, input logic tk);
    if (bt >= 3'd1 && bt <= 3'd5) begin
      if (tk) exp_t++;
      else exp_n++;
    end
  endtask

  task automatic drive(input logic [2:0] bt, input logic [15:0] pc, input logic [15:0] tgt);
    in_valid = 1'b1; in_btype = bt; in_pc = pc; in_target = tgt;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    drive(v.bt, v.pc, v.tgt);
    flags_wr = v.fwr; flags_in = v.fin; out_ready = 1'b1;
    #1 chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; flags_wr = 1'b0;
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".taken"}, 32'(out_taken), 32'(v.e_tk));
    chk({nm, ".pc"},    32'(out_branchpc), 32'(v.e_pc));
    chk({nm, ".err"},   32'(out_err), 32'(v.e_err));
    count(v.bt, v.e_tk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_target = '0; in_btype = '0;
    flags_wr = 1'b0; flags_in = '0; flush = 1'b0; out_ready = 1'b1;

    //             fwr  fin   bt    pc       tgt      tk  pc       err
    tv.push_back(mk(0, 2'b00, 3'd2, 16'h0000, 16'h0040, 1, 16'h0040, 0)); // beq, eq=1
    tv.push_back(mk(0, 2'b00, 3'd3, 16'h0000, 16'h0050, 0, 16'h0000, 0)); // bgt, gt=0
    tv.push_back(mk(1, 2'b10, 3'd3, 16'h0000, 16'h0080, 1, 16'h0080, 0)); // bypass
    tv.push_back(mk(0, 2'b00, 3'd3, 16'h0000, 16'h0090, 1, 16'h0090, 0)); // stored gt
    tv.push_back(mk(0, 2'b00, 3'd2, 16'h0000, 16'h0091, 0, 16'h0000, 0)); // stored eq=0
    tv.push_back(mk(0, 2'b00, 3'd0, 16'h0000, 16'h0033, 0, 16'h0000, 0)); // none
    tv.push_back(mk(0, 2'b00, 3'd1, 16'h0000, 16'h1234, 1, 16'h1234, 0)); // uncond
    tv.push_back(mk(0, 2'b00, 3'd6, 16'h0000, 16'h0044, 0, 16'h0000, 1)); // reserved
    tv.push_back(mk(0, 2'b00, 3'd7, 16'h0000, 16'h0045, 0, 16'h0000, 1)); // reserved
    tv.push_back(mk(0, 2'b00, 3'd5, 16'h0000, 16'h0046, 0, 16'h0000, 1)); // ret, empty
    tv.push_back(mk(0, 2'b00, 3'd4, 16'h0010, 16'h0200, 1, 16'h0200, 0)); // call
    tv.push_back(mk(0, 2'b00, 3'd5, 16'h0000, 16'h0000, 1, 16'h0011, 0)); // ret
    tv.push_back(mk(0, 2'b00, 3'd4, 16'hFFFF, 16'h0005, 1, 16'h0005, 0)); // call, link wraps
    tv.push_back(mk(0, 2'b00, 3'd5, 16'h0000, 16'h0000, 1, 16'h0000, 0)); // ret -> 0
    for (int i = 1; i <= 5; i++)
      tv.push_back(mk(0, 2'b00, 3'd4, 16'(i), 16'(16'h0100 + i), 1, 16'(16'h0100 + i), 0));
    for (int i = 6; i >= 3; i--)
      tv.push_back(mk(0, 2'b00, 3'd5, 16'h0000, 16'h0000, 1, 16'(i), 0));
    tv.push_back(mk(0, 2'b00, 3'd5, 16'h0000, 16'h0000, 0, 16'h0000, 1)); // oldest overwritten

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.pc",    32'(out_branchpc), 32'd0);
    chk("rst.taken", 32'(out_taken), 32'd0);
    chk("rst.err",   32'(out_err), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.st_t",  32'(stat_taken), 32'd0);
    chk("rst.st_n",  32'(stat_nottaken), 32'd0);
    @(posedge clk); #1;
    chk("idle.valid", 32'(out_valid), 32'd0);

    flags_wr = 1'b1; flags_in = 2'b01;
    @(posedge clk); #1;
    flags_wr = 1'b0;

    for (int i = 0; i < tv.size(); i++) run_vec(tv[i], $sformatf("v%0d", i));

    // Backpressure: result held, next op stalled, then accepted once out_ready returns.
    run_vec(mk(0, 2'b00, 3'd1, 16'h0000, 16'h0077, 1, 16'h0077, 0), "bp.first");
    out_ready = 1'b0;
    drive(3'd1, 16'h0000, 16'h0088);
    #1 chk("bp.ready0", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.valid%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp.pc%0d", c),    32'(out_branchpc), 32'h77);
      chk($sformatf("bp.taken%0d", c), 32'(out_taken), 32'd1);
      chk($sformatf("bp.ready%0d", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp.ready1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    count(3'd1, 1'b1);
    chk("bp.next_valid", 32'(out_valid), 32'd1);
    chk("bp.next_pc",    32'(out_branchpc), 32'h88);
    @(posedge clk); #1;
    chk("bp.drain", 32'(out_valid), 32'd0);

    // Flush concurrent with an accepted uncond: result dropped, still counted.
    drive(3'd1, 16'h0000, 16'h0099); flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    count(3'd1, 1'b1);
    chk("fl.valid", 32'(out_valid), 32'd0);
    chk("fl.taken", 32'(out_taken), 32'd0);
    chk("fl.pc",    32'(out_branchpc), 32'd0);

    // Flushed call still pushes its link.
    drive(3'd4, 16'h0020, 16'h0300); flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    count(3'd4, 1'b1);
    chk("flc.valid", 32'(out_valid), 32'd0);
    run_vec(mk(0, 2'b00, 3'd5, 16'h0000, 16'h0000, 1, 16'h0021, 0), "flc.ret");

    // Flush of a held result while stalled.
    run_vec(mk(0, 2'b00, 3'd1, 16'h0000, 16'h0055, 1, 16'h0055, 0), "flh.first");
    out_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flh.valid", 32'(out_valid), 32'd0);
    chk("flh.pc",    32'(out_branchpc), 32'd0);
    out_ready = 1'b1;

`ifdef BRANCH_RESOLVE_STATS_EN
    chk("stat.taken",    32'(stat_taken), 32'(exp_t));
    chk("stat.nottaken", 32'(stat_nottaken), 32'(exp_n));
`else
    chk("stat.taken",    32'(stat_taken), 32'd0);
    chk("stat.nottaken", 32'(stat_nottaken), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Registered, parametrised successor to the combinational branch resolver in the execute stage.
- Evaluates one branch op per accepted transaction and returns taken/target one cycle later over a valid/ready handshake.
- Holds an internal condition-flags register written by the compare path, with same-cycle bypass.
- Adds call/return support through an internal return-address stack (RAS).

Parameters:
- PC_W, 16, width of PC, target and RAS entries.
- RAS_DEPTH, 4, number of return-address stack entries (power of 2, ≥2).
- PC_INC, 1, link increment; link address = in_pc + PC_INC, modulo 2^PC_W.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  branch op offered.
- in_ready  out  1  unit can accept an op this cycle.
- in_pc  in  PC_W  PC of the branch op.
- in_target  in  PC_W  decoded branch target.
- in_btype  in  3  0=none, 1=uncond, 2=beq, 3=bgt, 4=call, 5=ret, 6/7=reserved.
- flags_wr  in  1  write flags register.
- flags_in  in  2  {gt, eq} from the compare unit.
- flush  in  1  discard the pending result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  branch taken.
- out_branchpc  out  PC_W  redirect PC; 0 when not taken.
- out_err  out  1  ret on empty RAS, or reserved btype.
- stat_taken  out  16  taken count (optional feature).
- stat_nottaken  out  16  not-taken count (optional feature).

Behaviour:
- Reset (rst=1 at clock edge) sets:
  - out_valid, out_taken, out_err = 0; out_branchpc = 0.
  - flags = 2'b00.
  - RAS count = 0, RAS pointer = 0.
  - stat counters = 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Latency is 1: the result is registered on the accept edge, and out_valid=1 the next cycle.
  - While out_valid && !out_ready, all out_* hold stable and no op is accepted.
  - Back-to-back ops sustain 1 op/cycle when out_ready=1.
- Flags:
  - flags_wr updates flags at the edge, independent of the handshake.
  - If flags_wr and an accept occur in the same cycle, evaluation uses flags_in (bypass); otherwise it uses the stored flags.
  - A flags write never alters an already-registered result.
- Evaluation by in_btype:
  - none: taken=0.
  - uncond: taken=1, pc=in_target.
  - beq: taken=eq.
  - bgt: taken=gt.
  - call: taken=1, pc=in_target; push in_pc+PC_INC.
  - ret:
    - RAS non-empty: taken=1, pc=top of stack, then pop.
    - RAS empty: taken=0, err=1, stack unchanged.
  - reserved: taken=0, err=1.
  - Whenever taken=0, out_branchpc=0.
- RAS:
  - Circular buffer.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH and the pointer wraps.
  - RAS is updated only on accept. Accepted ops are not cancelled by flush, so a flush does not undo a push or pop.
- Flush:
  - At the edge, clears out_valid, out_taken, out_err and out_branchpc to 0.
  - If an accept occurs in the same cycle, flush wins: the result is dropped, but the op's RAS/stat side effects still apply.
  - Flags are unaffected.
- Stats:
  - Counted at accept of btype 1–5; reserved types are not counted.
  - Counters saturate at 16'hFFFF.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- Defined: stat_taken and stat_nottaken count as described under Behaviour, reset to 0, and saturate.
- Undefined: no counter logic is built; stat_taken and stat_nottaken are tied to 0.

Test Plan:
- Reset, then idle: out_valid=0, out_branchpc=0, in_ready=1.
- Flags:
  - flags_wr with flags_in=2'b01, then beq with target 16'h0040 -> next cycle out_valid=1, taken=1, branchpc=16'h0040.
  - bgt in the same cycle -> taken=0, branchpc=0.
- Bypass: in one cycle, flags_wr with flags_in=2'b10 plus bgt with target 16'h0080 accepted -> taken=1, branchpc=16'h0080; stored flags afterwards = 2'b10.
- RAS (depth 4):
  - call at pc 16'h0010 -> ret gives branchpc=16'h0011.
  - 5 calls at pcs 1..5, then 5 rets -> returns 6,5,4,3 then ret #5 gives taken=0, err=1.
- Backpressure: out_ready=0 for 3 cycles with an op pending -> out_* stable, in_ready=0. Then out_ready=1 -> the next op is accepted that cycle, and its result appears the cycle after.
- Flush and stats:
  - flush concurrent with an accepted uncond -> out_valid=0 next cycle.
  - With BRANCH_RESOLVE_STATS_EN defined, stat_taken increments by 1 for that op.
